// File: rtl/serial_word_feeder.sv
// serial_word_feeder: accepts parallel words over valid/ready, buffers one
// word, and streams each word LSB first as ser_data/ser_en, followed by a
// one-cycle send_data pulse and a wrap-around completed-word count.
module serial_word_feeder #(
    parameter int BUS_WIDTH = 16,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BUS_WIDTH-1:0] word_in,
    input  logic                 word_valid,
    output logic                 word_ready,
    output logic                 ser_data,
    output logic                 ser_en,
    output logic                 send_data,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] words_sent
);

    localparam int BIT_W = (BUS_WIDTH > 1) ? $clog2(BUS_WIDTH) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(BUS_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, SEND} state_t;

    state_t               state, state_next;
    logic [BUS_WIDTH-1:0] hold;
    logic                 hold_full, hold_full_next;
    logic [BUS_WIDTH-1:0] shift, shift_next;
    logic [BIT_W-1:0]     cnt, cnt_next;
    logic                 take;
    logic                 load;

    // Ready depends only on the buffer flag, so no combinational path from word_valid.
    assign word_ready = !hold_full;
    assign take       = word_valid && !hold_full;

    // Next-state logic; a load moves the held word into the shifter and frees the buffer.
    always_comb begin
        state_next     = state;
        hold_full_next = hold_full;
        shift_next     = shift;
        cnt_next       = cnt;
        load           = 1'b0;
        case (state)
            IDLE: begin
                if (hold_full) load = 1'b1;
            end
            SHIFT: begin
                shift_next = shift >> 1;
                cnt_next   = cnt + 1'b1;
                if (cnt == LAST_BIT) state_next = SEND;
            end
            SEND: begin
                if (hold_full) load = 1'b1;
                else           state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (load) begin
            shift_next     = hold;
            cnt_next       = '0;
            state_next     = SHIFT;
            hold_full_next = 1'b0;
        end
        // Transfer and load are mutually exclusive since ready is low while the buffer is full.
        if (take) hold_full_next = 1'b1;
    end

    // Core state registers and the one-word input buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            hold      <= '0;
            hold_full <= 1'b0;
            shift     <= '0;
            cnt       <= '0;
        end else begin
            state     <= state_next;
            hold_full <= hold_full_next;
            shift     <= shift_next;
            cnt       <= cnt_next;
            if (take) hold <= word_in;
        end
    end

    // Registered outputs, computed from the next state so they line up with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ser_en     <= 1'b0;
            ser_data   <= 1'b0;
            send_data  <= 1'b0;
            busy       <= 1'b0;
            words_sent <= '0;
        end else begin
            ser_en    <= (state_next == SHIFT);
            ser_data  <= (state_next == SHIFT) && shift_next[0];
            send_data <= (state_next == SEND);
            busy      <= (state_next != IDLE) || hold_full_next;
            if (state == SEND) words_sent <= words_sent + 1'b1;
        end
    end

endmodule

// File: tb/tb_serial_word_feeder.sv
// Bench for serial_word_feeder: directed timing scenarios plus random traffic,
// checked by a scoreboard of accepted words against the serial stream, a
// downstream serial-to-parallel model and a completed-word count.
module tb_serial_word_feeder;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  word_in = '0;
    logic          word_valid = 1'b0;
    logic          word_ready, ser_data, ser_en, send_data, busy;
    logic [15:0]   words_sent;
    logic          w2_ready, w2_ser_data, w2_ser_en, w2_send, w2_busy;
    logic [1:0]    words_sent2;

    serial_word_feeder #(.BUS_WIDTH(W), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .word_in(word_in), .word_valid(word_valid),
        .word_ready(word_ready), .ser_data(ser_data), .ser_en(ser_en),
        .send_data(send_data), .busy(busy), .words_sent(words_sent)
    );

    // Same stimulus, narrow counter, to exercise wrap-around.
    serial_word_feeder #(.BUS_WIDTH(W), .CNT_WIDTH(2)) dut_w2 (
        .clk(clk), .rst(rst), .word_in(word_in), .word_valid(word_valid),
        .word_ready(w2_ready), .ser_data(w2_ser_data), .ser_en(w2_ser_en),
        .send_data(w2_send), .busy(w2_busy), .words_sent(words_sent2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Downstream serial-to-parallel register: new bit enters at the MSB.
    logic [W-1:0] ds;
    always @(posedge clk or posedge rst) begin
        if (rst)         ds <= '0;
        else if (ser_en) ds <= {ser_data, ds[W-1:1]};
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard state
    logic [W-1:0] exp_q[$];
    int           first_q[$];
    int           send_q[$];
    logic [15:0]  exp_ws = '0;
    int           nbits = 0;
    logic [W-1:0] coll = '0;

    function automatic int fq(input int i);
        return (i < first_q.size()) ? first_q[i] : -1;
    endfunction
    function automatic int sq(input int i);
        return (i < send_q.size()) ? send_q[i] : -1;
    endfunction

    // Monitor: samples on the falling edge, pops expected words on send_data.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                nbits  = 0;
                exp_ws = '0;
            end else begin
                chk("send_with_en", send_data & ser_en, 0);
                if (!ser_en) chk("ser_data_idle", ser_data, 0);
                chk("busy", busy, exp_q.size() != 0);
                chk("words_sent", words_sent, exp_ws);
                chk("words_sent_w2", words_sent2, exp_ws[1:0]);
                chk("lockstep_w2", {w2_ready, w2_ser_data, w2_ser_en, w2_send, w2_busy},
                    {word_ready, ser_data, ser_en, send_data, busy});
                if (ser_en) begin
                    if (nbits == 0) first_q.push_back(cyc);
                    if (nbits < W) coll[nbits] = ser_data;
                    nbits++;
                end
                if (send_data) begin
                    send_q.push_back(cyc);
                    chk("bits_per_word", nbits, W);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_send", 1, 0);
                    end else begin
                        logic [W-1:0] e;
                        e = exp_q.pop_front();
                        chk("serial_word", coll, e);
                        chk("downstream_word", ds, e);
                    end
                    nbits  = 0;
                    exp_ws = exp_ws + 1'b1;
                end
            end
        end
    end

    // Offer a word until accepted; returns handshake cycle and stall count.
    task automatic send_word(input logic [W-1:0] w, output int hs, output int stalls);
        word_in    = w;
        word_valid = 1'b1;
        stalls     = 0;
        hs         = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (word_ready) begin
                hs = cyc;
                @(posedge clk);
                exp_q.push_back(w);
                #1;
                word_valid = 1'b0;
                word_in    = W'($urandom);
                return;
            end
            stalls++;
        end
        chk("handshake_timeout", 0, 1);
        word_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) done = 1'b1;
        end
        if (!done) chk("idle_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycle(input int t);
        for (int i = 0; i < 1000 && cyc < t; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int h1, h2, h3, st;
        int ws_seq[5];

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ser_en", ser_en, 0);
        chk("rst_ser_data", ser_data, 0);
        chk("rst_send", send_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_words_sent", words_sent, 0);
        chk("rst_ready", word_ready, 1);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Single word
        first_q.delete(); send_q.delete();
        send_word(16'hA5C3, h1, st);
        chk("c1_ready", word_ready, 0);
        chk("c1_busy", busy, 1);
        @(posedge clk); #1;
        chk("c2_ready", word_ready, 1);
        chk("c2_ser_en", ser_en, 1);
        wait_idle();
        chk("single_first_bit", fq(0), h1 + 2);
        chk("single_send", sq(0), h1 + 18);
        chk("single_send_count", send_q.size(), 1);
        chk("single_words_sent", words_sent, 1);

        // Back-to-back
        first_q.delete(); send_q.delete();
        send_word(16'h0001, h1, st);
        send_word(16'h8000, h2, st);
        chk("b2b_hs2", h2, h1 + 2);
        wait_idle();
        chk("b2b_send0", sq(0), h1 + 18);
        chk("b2b_first1", fq(1), h1 + 19);
        chk("b2b_send1", sq(1), h1 + 35);

        // Backpressure
        first_q.delete(); send_q.delete();
        send_word(16'hBEEF, h1, st);
        send_word(16'h5A5A, h2, st);
        send_word(16'h1234, h3, st);
        chk("bp_hs3", h3, h1 + 19);
        chk("bp_stalls", st, 16);
        wait_idle();
        chk("bp_sends", send_q.size(), 3);

        // Handshake during SEND with empty buffer
        first_q.delete(); send_q.delete();
        send_word(16'h0F0F, h1, st);
        wait_cycle(h1 + 18);
        send_word(16'hFFFF, h2, st);
        chk("send_hs", h2, h1 + 18);
        wait_idle();
        chk("send_pulse", sq(0), h1 + 18);
        chk("send_gap_first", fq(1), h1 + 20);

        // Reset mid-shift
        first_q.delete(); send_q.delete();
        send_word(16'h00FF, h1, st);
        wait_cycle(h1 + 9);
        rst = 1'b1;
        #1;
        chk("mid_rst_ser_en", ser_en, 0);
        chk("mid_rst_ser_data", ser_data, 0);
        chk("mid_rst_send", send_data, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_words_sent", words_sent, 0);
        chk("mid_rst_ready", word_ready, 1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("mid_rst_no_send", send_q.size(), 0);
        send_word(16'h3C3C, h1, st);
        wait_idle();
        chk("post_rst_sends", send_q.size(), 1);
        chk("post_rst_words_sent", words_sent, 1);

        // Counter wrap on the 2-bit instance
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            send_word(W'($urandom), h1, st);
            wait_idle();
            ws_seq[i] = int'(words_sent2);
        end
        chk("wrap_0", ws_seq[0], 1);
        chk("wrap_1", ws_seq[1], 2);
        chk("wrap_2", ws_seq[2], 3);
        chk("wrap_3", ws_seq[3], 0);
        chk("wrap_4", ws_seq[4], 1);

        // Random traffic with random gaps and junk on word_in while idle
        for (int i = 0; i < 40; i++) begin
            int gap;
            gap = $urandom_range(0, 20);
            for (int g = 0; g < gap; g++) begin
                word_in = W'($urandom);
                @(posedge clk); #1;
            end
            send_word(W'($urandom), h1, st);
        end
        wait_idle();
        chk("rand_words_sent", words_sent, 45);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
